commit_sequencer: RTL and testbench

COMMIT_SEQUENCER -- requirements
Module: commit_sequencer

---
 rtl/commit_sequencer_pkg.sv | 19 +
 rtl/commit_sequencer.sv | 115 +++++++++++
 tb/tb_commit_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/commit_sequencer_pkg.sv
// rtl/commit_sequencer_pkg.sv - head-kind and FSM state encodings shared by the commit sequencer
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

package commit_sequencer_pkg;

  localparam logic [1:0] KIND_REG    = 2'b00;
  localparam logic [1:0] KIND_STORE  = 2'b01;
  localparam logic [1:0] KIND_BRANCH = 2'b10;
  localparam logic [1:0] KIND_NOP    = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } cs_state_t;

endpackage

// File: rtl/commit_sequencer.sv
// rtl/commit_sequencer.sv - retires the ROB head one entry per cycle: register writes, stores and branch flushes
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module commit_sequencer
  import commit_sequencer_pkg::*;
#(
  parameter int ROB_W      = `ROB_SIZE_WIDTH,
  parameter int FLUSH_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rob_valid,
  input  logic [1:0]       rob_kind,
  input  logic [4:0]       rob_rd,
  input  logic [31:0]      rob_val,
  input  logic [ROB_W-1:0] rob_id,
  input  logic             rob_mispredict,
  input  logic [31:0]      rob_target_pc,
  input  logic             lsb_store_done,
  output logic             cs_pop,
  output logic             rf_enable,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_val,
  output logic [ROB_W-1:0] rf_commit_id,
  output logic             lsb_store_req,
  output logic [ROB_W-1:0] lsb_store_id,
  output logic             flush,
  output logic [31:0]      flush_pc,
  output logic [31:0]      commit_count
);

  cs_state_t  state, state_n;
  logic [3:0] hold_cnt, hold_n;
  logic       store_start, branch_flush, reg_write;

  always_comb begin
    state_n      = state;
    hold_n       = hold_cnt;
    cs_pop       = 1'b0;
    store_start  = 1'b0;
    branch_flush = 1'b0;
    reg_write    = 1'b0;
    if (rdy) begin
      case (state)
        ST_RUN: begin
          if (rob_valid) begin
            if (rob_kind == KIND_STORE) begin
              store_start = 1'b1;
              state_n     = ST_STORE_WAIT;
            end else begin
              cs_pop    = 1'b1;
              reg_write = (rob_kind == KIND_REG) && (rob_rd != 5'd0);
              if (rob_kind == KIND_BRANCH && rob_mispredict) begin
                branch_flush = 1'b1;
                hold_n       = 4'(FLUSH_HOLD);
                state_n      = ST_FLUSH;
              end
            end
          end
        end
        ST_STORE_WAIT: begin
          if (lsb_store_done) begin
            cs_pop  = 1'b1;
            state_n = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // Quiet period: leave once the counter has drained to zero.
          hold_n = (hold_cnt == 4'd0) ? 4'd0 : hold_cnt - 4'd1;
          if (hold_n == 4'd0) state_n = ST_RUN;
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      hold_cnt      <= 4'd0;
      commit_count  <= 32'd0;
      rf_enable     <= 1'b0;
      rf_rd         <= 5'd0;
      rf_val        <= 32'd0;
      rf_commit_id  <= '0;
      lsb_store_req <= 1'b0;
      lsb_store_id  <= '0;
      flush         <= 1'b0;
      flush_pc      <= 32'd0;
    end else if (rdy) begin
      state        <= state_n;
      hold_cnt     <= hold_n;
      commit_count <= commit_count + {31'd0, cs_pop};
      rf_enable    <= reg_write;
      if (reg_write) begin
        rf_rd        <= rob_rd;
        rf_val       <= rob_val;
        rf_commit_id <= rob_id;
      end
      flush <= branch_flush;
      if (branch_flush) flush_pc <= rob_target_pc;
      // Level request held across STORE_WAIT, dropped with the retiring pop.
      if (store_start) begin
        lsb_store_req <= 1'b1;
        lsb_store_id  <= rob_id;
      end else if (state == ST_STORE_WAIT && cs_pop) begin
        lsb_store_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_commit_sequencer.sv
// tb/tb_commit_sequencer.sv - self-checking bench for commit_sequencer
module tb_commit_sequencer;
  import commit_sequencer_pkg::*;

  localparam int ROB_W = 4;
  localparam int HOLD  = 2;

  logic             clk = 1'b0;
  logic             rst, rdy, rob_valid, rob_mispredict, lsb_store_done;
  logic [1:0]       rob_kind;
  logic [4:0]       rob_rd;
  logic [31:0]      rob_val, rob_target_pc;
  logic [ROB_W-1:0] rob_id;
  logic             cs_pop, rf_enable, lsb_store_req, flush;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_val, flush_pc, commit_count;
  logic [ROB_W-1:0] rf_commit_id, lsb_store_id;

  commit_sequencer #(.ROB_W(ROB_W), .FLUSH_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_valid(rob_valid), .rob_kind(rob_kind),
    .rob_rd(rob_rd), .rob_val(rob_val), .rob_id(rob_id), .rob_mispredict(rob_mispredict),
    .rob_target_pc(rob_target_pc), .lsb_store_done(lsb_store_done), .cs_pop(cs_pop),
    .rf_enable(rf_enable), .rf_rd(rf_rd), .rf_val(rf_val), .rf_commit_id(rf_commit_id),
    .lsb_store_req(lsb_store_req), .lsb_store_id(lsb_store_id), .flush(flush),
    .flush_pc(flush_pc), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_count = 32'd0;

  typedef struct packed {
    logic [4:0]       rd;
    logic [31:0]      val;
    logic [ROB_W-1:0] id;
  } wr_t;
  wr_t sb[$];
  wr_t mon_e;
  logic rdy_at_edge;

  typedef struct {
    logic             v;
    logic [1:0]       kind;
    logic [4:0]       rd;
    logic [31:0]      val;
    logic [ROB_W-1:0] id;
    logic             mis;
    logic [31:0]      tpc;
    logic             exp_pop;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Register-file writes are compared against the queue of expected writes.
  always @(posedge clk) begin
    rdy_at_edge = rdy;
    #1;
    if (!rst && rdy_at_edge && rf_enable) begin
      if (sb.size() == 0) begin
        check("rf_unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rf_rd", 64'(rf_rd), 64'(mon_e.rd));
        check("rf_val", 64'(rf_val), 64'(mon_e.val));
        check("rf_commit_id", 64'(rf_commit_id), 64'(mon_e.id));
      end
    end
  end

  // Called at 2 time units after a rising edge; returns at the same phase of the next cycle.
  task automatic cycle(input string nm, input logic v, input logic [1:0] k, input logic [4:0] rd,
                       input logic [31:0] val, input logic [ROB_W-1:0] id, input logic mis,
                       input logic [31:0] tpc, input logic done, input logic r, input logic exp_pop);
    wr_t e;
    rob_valid = v; rob_kind = k; rob_rd = rd; rob_val = val; rob_id = id;
    rob_mispredict = mis; rob_target_pc = tpc; lsb_store_done = done; rdy = r;
    #4;
    check({nm, "_pop"}, 64'(cs_pop), 64'(exp_pop));
    if (exp_pop) begin
      exp_count = exp_count + 32'd1;
      if (k == KIND_REG && rd != 5'd0) begin
        e.rd = rd; e.val = val; e.id = id;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input string nm);
    cycle(nm, 1'b0, KIND_NOP, 5'd0, 32'd0, '0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_rf_enable"}, 64'(rf_enable), 64'd0);
    check({nm, "_rf_rd"}, 64'(rf_rd), 64'd0);
    check({nm, "_rf_val"}, 64'(rf_val), 64'd0);
    check({nm, "_rf_commit_id"}, 64'(rf_commit_id), 64'd0);
    check({nm, "_lsb_store_req"}, 64'(lsb_store_req), 64'd0);
    check({nm, "_lsb_store_id"}, 64'(lsb_store_id), 64'd0);
    check({nm, "_flush"}, 64'(flush), 64'd0);
    check({nm, "_flush_pc"}, 64'(flush_pc), 64'd0);
    check({nm, "_commit_count"}, 64'(commit_count), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, KIND_REG,    5'd5,  32'hDEADBEEF, 4'd3, 1'b0, 32'd0,      1'b1};
    vecs[1] = '{1'b1, KIND_REG,    5'd0,  32'h12345678, 4'd4, 1'b0, 32'd0,      1'b1};
    vecs[2] = '{1'b1, KIND_NOP,    5'd7,  32'h0BADF00D, 4'd5, 1'b1, 32'h2000,   1'b1};
    vecs[3] = '{1'b1, KIND_BRANCH, 5'd9,  32'h0,        4'd6, 1'b0, 32'h3000,   1'b1};
    vecs[4] = '{1'b0, KIND_REG,    5'd10, 32'hCAFE0000, 4'd7, 1'b0, 32'd0,      1'b0};
    vecs[5] = '{1'b1, KIND_REG,    5'd31, 32'hFFFFFFFF, 4'd15, 1'b1, 32'h4000,  1'b1};

    rst = 1'b1; rdy = 1'b1; rob_valid = 1'b0; rob_kind = KIND_NOP; rob_rd = 5'd0;
    rob_val = 32'd0; rob_id = '0; rob_mispredict = 1'b0; rob_target_pc = 32'd0;
    lsb_store_done = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset_pop", 64'(cs_pop), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].v, vecs[i].kind, vecs[i].rd, vecs[i].val, vecs[i].id,
            vecs[i].mis, vecs[i].tpc, 1'b0, 1'b1, vecs[i].exp_pop);
      check($sformatf("vec%0d_count", i), 64'(commit_count), 64'(exp_count));
      check($sformatf("vec%0d_flush", i), 64'(flush), 64'd0);
      check($sformatf("vec%0d_req", i), 64'(lsb_store_req), 64'd0);
    end
    check("first_reg_write_id", 64'(rf_enable), 64'd1);

    cycle("done_in_run", 1'b0, KIND_REG, 5'd1, 32'd1, '0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    cycle("store_issue", 1'b1, KIND_STORE, 5'd2, 32'h55, 4'd6, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("store_req_w%0d", i), 64'(lsb_store_req), 64'd1);
      check($sformatf("store_id_w%0d", i), 64'(lsb_store_id), 64'd6);
      cycle($sformatf("store_wait%0d", i), 1'b1, KIND_STORE, 5'd2, 32'h55, 4'd6, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    end
    check("store_req_w3", 64'(lsb_store_req), 64'd1);
    cycle("store_done", 1'b1, KIND_STORE, 5'd2, 32'h55, 4'd6, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    check("store_req_cleared", 64'(lsb_store_req), 64'd0);
    check("store_count", 64'(commit_count), 64'(exp_count));
    cycle("after_store", 1'b1, KIND_REG, 5'd3, 32'hA5A5A5A5, 4'd1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

    cycle("frz_issue", 1'b1, KIND_STORE, 5'd0, 32'd0, 4'd9, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle("frz_done", 1'b1, KIND_STORE, 5'd0, 32'd0, 4'd9, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("frz_req_held", 64'(lsb_store_req), 64'd1);
    check("frz_count_held", 64'(commit_count), 64'(exp_count));
    cycle("frz_still_wait", 1'b1, KIND_STORE, 5'd0, 32'd0, 4'd9, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle("frz_release", 1'b1, KIND_STORE, 5'd0, 32'd0, 4'd9, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
    check("frz_req_cleared", 64'(lsb_store_req), 64'd0);

    cycle("br_mis", 1'b1, KIND_BRANCH, 5'd0, 32'd0, 4'd2, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b1);
    check("flush_set", 64'(flush), 64'd1);
    check("flush_pc", 64'(flush_pc), 64'h1000);
    cycle("flush_hold0", 1'b1, KIND_REG, 5'd4, 32'h44, 4'd4, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("flush_pulse_end", 64'(flush), 64'd0);
    cycle("flush_hold1", 1'b1, KIND_REG, 5'd4, 32'h44, 4'd4, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle("flush_exit", 1'b1, KIND_REG, 5'd4, 32'h44, 4'd4, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check("flush_count", 64'(commit_count), 64'(exp_count));

    for (int i = 0; i < 8; i++) begin
      cycle($sformatf("b2b%0d", i), 1'b1, KIND_REG, 5'(i + 1), $urandom, 4'(i), 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    end
    check("b2b_count", 64'(commit_count), 64'(exp_count));
    idle("b2b_drain");
    check("b2b_rf_idle", 64'(rf_enable), 64'd0);

    cycle("rst_br", 1'b1, KIND_BRANCH, 5'd0, 32'd0, 4'd1, 1'b1, 32'h8000, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_flush");
    exp_count = 32'd0;
    @(posedge clk); #2;
    rst = 1'b0;
    cycle("post_rst", 1'b1, KIND_REG, 5'd6, 32'h600DCAFE, 4'd8, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    check("post_rst_flush", 64'(flush), 64'd0);
    check("post_rst_count", 64'(commit_count), 64'd1);
    idle("final");
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
